core_mem_pipe: RTL

Parametrised successor to the fixed two-cycle MEM stage. It accepts one EX-stage op at a time over a valid/ready handshake and drives a valid/ready data-bus request with a variable-latency response, stalling EX while a memory op is in flight. It does byte-lane alignment, strobe generation and load sign/zero extension for XLEN 32 or 64. It emits one registered writeback record per completed op. Coprocessor results, link PC and other non-memory results arrive already muxed on in_result.

---
 rtl/core_mem_pipe_pkg.sv | 30 +++
 rtl/core_mem_pipe_if.sv | 51 +++++
 rtl/core_mem_pipe_lane_align.sv | 39 +++
 rtl/core_mem_pipe.sv | 138 +++++++++++++
 4 files changed

// File: rtl/core_mem_pipe_pkg.sv
// rtl/core_mem_pipe_pkg.sv - shared types for the memory pipeline stage
package core_mem_pipe_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_pipe_state_t;

  // Fields of an accepted memory op that outlive the EX handshake
  typedef struct packed {
    logic      is_store;
    mem_size_t size;
    logic      sign_ext;
    logic [2:0] off;
    logic      write_enable;
  } mem_op_t;

  function automatic logic [3:0] size_bytes(input mem_size_t size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/core_mem_pipe_if.sv
// rtl/core_mem_pipe_if.sv - EX op, data bus and writeback signal bundle
interface core_mem_pipe_if #(
  parameter int XLEN  = 64,
  parameter int REG_W = 5
);
  localparam int STRB_W = XLEN / 8;

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_addr;
  logic [XLEN-1:0]   in_wdata;
  logic [XLEN-1:0]   in_result;
  logic              in_is_load;
  logic              in_is_store;
  logic [1:0]        in_size;
  logic              in_signed;
  logic [REG_W-1:0]  in_regnum;
  logic              in_write_enable;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_req_addr;
  logic              mem_req_we;
  logic [STRB_W-1:0] mem_req_strb;
  logic [XLEN-1:0]   mem_req_wdata;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_rdata;

  logic              wb_valid;
  logic [REG_W-1:0]  wb_regnum;
  logic              wb_write_enable;
  logic [XLEN-1:0]   wb_data;
  logic              misalign;

  modport slave (
    input  in_valid, in_addr, in_wdata, in_result, in_is_load, in_is_store,
           in_size, in_signed, in_regnum, in_write_enable,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output in_ready, mem_req_valid, mem_req_addr, mem_req_we, mem_req_strb,
           mem_req_wdata, wb_valid, wb_regnum, wb_write_enable, wb_data, misalign
  );

  modport master (
    output in_valid, in_addr, in_wdata, in_result, in_is_load, in_is_store,
           in_size, in_signed, in_regnum, in_write_enable,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  in_ready, mem_req_valid, mem_req_addr, mem_req_we, mem_req_strb,
           mem_req_wdata, wb_valid, wb_regnum, wb_write_enable, wb_data, misalign
  );

endinterface

// File: rtl/core_mem_pipe_lane_align.sv
// rtl/core_mem_pipe_lane_align.sv - byte-lane strobe/shift, load extraction and misalign decode
module mem_lane_align
  import core_mem_pipe_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int STRB_W = XLEN / 8,
  localparam int OFF_W = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]  off,
  input  mem_size_t         size,
  input  logic              sign_ext,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [STRB_W-1:0] strb,
  output logic [XLEN-1:0]   wdata_lane,
  output logic [XLEN-1:0]   load_data,
  output logic              misalign
);

  logic [XLEN-1:0] shifted;
  logic [63:0]     word_ext;

  always_comb begin
    strb       = STRB_W'((17'd1 << size_bytes(size)) - 17'd1) << off;
    wdata_lane = wdata << {off, 3'b000};
    shifted    = rdata >> {off, 3'b000};
    word_ext   = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
    case (size)
      BYTE:    load_data = {{(XLEN-8){sign_ext & shifted[7]}}, shifted[7:0]};
      HALF:    load_data = {{(XLEN-16){sign_ext & shifted[15]}}, shifted[15:0]};
      WORD:    load_data = word_ext[XLEN-1:0];
      default: load_data = shifted;
    endcase
    // A dword has no legal lane on a 32-bit bus
    misalign = (|(off & OFF_W'(size_bytes(size) - 4'd1))) |
               ((size == DWORD) && (XLEN == 32));
  end

endmodule

// File: rtl/core_mem_pipe.sv
// rtl/core_mem_pipe.sv - MEM stage: EX handshake, variable-latency data bus, one writeback per op
module core_mem_pipe
  import core_mem_pipe_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int REG_W = 5
) (
  input logic            clock,
  input logic            reset_n,
  input logic            flush,
  core_mem_pipe_if.slave bus
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  mem_pipe_state_t   state, state_next;
  mem_op_t           op;
  logic [REG_W-1:0]  op_regnum;
  logic              accept;
  logic              is_mem;

  logic [OFF_W-1:0]  la_off;
  mem_size_t         la_size;
  logic              la_sign;
  logic [STRB_W-1:0] la_strb;
  logic [XLEN-1:0]   la_wdata;
  logic [XLEN-1:0]   la_load;
  logic              la_misalign;

  assign accept = bus.in_valid & bus.in_ready & ~flush;
  assign is_mem = bus.in_is_load | bus.in_is_store;

  // One aligner serves both the incoming op (IDLE) and the latched op (RESP)
  always_comb begin
    if (state == IDLE) begin
      la_off  = bus.in_addr[OFF_W-1:0];
      la_size = mem_size_t'(bus.in_size);
      la_sign = bus.in_signed;
    end else begin
      la_off  = op.off[OFF_W-1:0];
      la_size = op.size;
      la_sign = op.sign_ext;
    end
  end

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .off        (la_off),
    .size       (la_size),
    .sign_ext   (la_sign),
    .wdata      (bus.in_wdata),
    .rdata      (bus.mem_resp_rdata),
    .strb       (la_strb),
    .wdata_lane (la_wdata),
    .load_data  (la_load),
    .misalign   (la_misalign)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mem && !la_misalign) state_next = REQ;
      REQ:     if (bus.mem_req_ready) state_next = op.is_store ? IDLE : RESP;
      RESP:    if (bus.mem_resp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready      = (state == IDLE);
    bus.mem_req_valid = (state == REQ);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op                  <= '0;
      op_regnum           <= '0;
      bus.mem_req_addr    <= '0;
      bus.mem_req_we      <= 1'b0;
      bus.mem_req_strb    <= '0;
      bus.mem_req_wdata   <= '0;
      bus.wb_valid        <= 1'b0;
      bus.wb_regnum       <= '0;
      bus.wb_write_enable <= 1'b0;
      bus.wb_data         <= '0;
      bus.misalign        <= 1'b0;
    end else begin
      bus.wb_valid <= 1'b0;
      bus.misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && is_mem && la_misalign) begin
            bus.misalign <= 1'b1;
          end else if (accept && is_mem) begin
            op <= '{is_store:     bus.in_is_store,
                    size:         mem_size_t'(bus.in_size),
                    sign_ext:     bus.in_signed,
                    off:          3'(bus.in_addr[OFF_W-1:0]),
                    write_enable: bus.in_write_enable};
            op_regnum         <= bus.in_regnum;
            bus.mem_req_addr  <= {bus.in_addr[XLEN-1:OFF_W], OFF_W'(0)};
            bus.mem_req_we    <= bus.in_is_store;
            bus.mem_req_strb  <= la_strb;
            bus.mem_req_wdata <= la_wdata;
          end else if (accept) begin
            bus.wb_valid        <= 1'b1;
            bus.wb_regnum       <= bus.in_regnum;
            bus.wb_write_enable <= bus.in_write_enable;
            bus.wb_data         <= bus.in_result;
          end
        end
        REQ: begin
          if (bus.mem_req_ready && op.is_store) begin
            bus.wb_valid        <= 1'b1;
            bus.wb_regnum       <= op_regnum;
            bus.wb_write_enable <= 1'b0;
            bus.wb_data         <= '0;
          end
        end
        RESP: begin
          if (bus.mem_resp_valid) begin
            bus.wb_valid        <= 1'b1;
            bus.wb_regnum       <= op_regnum;
            bus.wb_write_enable <= op.write_enable;
            bus.wb_data         <= la_load;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
